// File: rtl/mul_pkg.sv
// Shared helpers for pipe_mul: width arithmetic, pipeline latency and parameter legality.
package mul_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Accept-to-out_valid latency: one partial-product stage plus the adder tree.
    function automatic int unsigned lat(input int unsigned width);
        return 1 + clog2(width);
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= 4) && (width <= 32) && ((width & (width - 1)) == 0);
    endfunction

endpackage

// File: rtl/mul_add_stage.sv
// One adder-tree level of pipe_mul: sums adjacent row pairs and registers them with valid/tag.
module mul_add_stage
    import mul_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned W     = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adv,
    input  logic                       in_valid,
    input  logic [N_IN-1:0][W-1:0]     in_rows,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [N_IN/2-1:0][W-1:0]   out_rows,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int unsigned N_OUT = N_IN / 2;

    logic [N_OUT-1:0][W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            sum[j] = in_rows[2*j] + in_rows[2*j+1];
        end
    end

    // Bubbles shift with adv just like valid slots; everything freezes when adv is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rows  <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_rows  <= sum;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/pipe_mul.sv
// Fully pipelined shift-and-add multiplier with valid/ready flow control and a sideband tag.
// Define PIPE_MUL_SIGNED_EN to honour mode_signed; otherwise operands are always unsigned.
module pipe_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
    input  logic                 mode_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned L     = clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned NROWS = 2 * WIDTH - 1;

    if (!(width_ok(WIDTH) && TAG_W >= 1)) begin : g_bad_param
        $fatal(1, "pipe_mul: WIDTH must be a power of two in 4..32 and TAG_W >= 1");
    end

    logic                    adv;
    logic [PW-1:0]           ext_a;
    logic [WIDTH-1:0][PW-1:0] pp;
    logic [WIDTH-1:0][PW-1:0] pp_q;
    logic                    vld0_q;
    logic [TAG_W-1:0]        tag0_q;

    // All tree levels packed together; level k starts at row 2*WIDTH - 2*(WIDTH >> k).
    logic [NROWS-1:0][PW-1:0] rows;
    logic [L:0]               vld;
    logic [L:0][TAG_W-1:0]    tag;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifndef PIPE_MUL_SIGNED_EN
    logic unused_mode;
    assign unused_mode = mode_signed;
`endif

    always_comb begin
        ext_a = {{WIDTH{1'b0}}, mul_a};
`ifdef PIPE_MUL_SIGNED_EN
        if (mode_signed) ext_a = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
`endif
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mul_b[i]) pp[i] = ext_a << i;
        end
`ifdef PIPE_MUL_SIGNED_EN
        // mul_b's MSB carries weight -2^(WIDTH-1) in two's complement.
        if (mode_signed) pp[WIDTH-1] = -pp[WIDTH-1];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0_q <= 1'b0;
            pp_q   <= '0;
            tag0_q <= '0;
        end else if (adv) begin
            vld0_q <= in_valid;
            pp_q   <= pp;
            tag0_q <= in_tag;
        end
    end

    assign rows[WIDTH-1:0] = pp_q;
    assign vld[0]          = vld0_q;
    assign tag[0]          = tag0_q;

    for (genvar k = 0; k < L; k++) begin : g_tree
        localparam int unsigned NI = WIDTH >> k;
        localparam int unsigned IB = 2 * WIDTH - 2 * NI;
        localparam int unsigned OB = IB + NI;

        mul_add_stage #(
            .N_IN  (NI),
            .W     (PW),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_valid  (vld[k]),
            .in_rows   (rows[IB+NI-1:IB]),
            .in_tag    (tag[k]),
            .out_valid (vld[k+1]),
            .out_rows  (rows[OB+NI/2-1:OB]),
            .out_tag   (tag[k+1])
        );
    end

    assign out_valid = vld[L];
    assign result    = rows[NROWS-1];
    assign out_tag   = tag[L];

endmodule
